mjp_game_engine: RTL and testbench



---
 rtl/mjp_pkg.sv | 63 ++++++
 rtl/mjp_game_engine_digit_enc.sv | 28 ++
 rtl/mjp_game_engine.sv | 159 +++++++++++++++
 tb/tb_mjp_game_engine.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mjp_pkg.sv
// mjp_pkg: shared definitions for the muk-jji-ppa game engine.
//   - 2-bit sign codes (ROCK, SCISSORS, PAPER, INVALID)
//   - FSM state encoding
//   - 13-bit display patterns for signs, results and score digits.
//     Patterns are written MSB-first into [0:12] vectors, so the leftmost
//     literal character lands on bit 0, which is what the display monitor expects.
// Helper functions: sign_pat (sign -> display pattern), beats (RPS rule).
package mjp_pkg;

    typedef logic [1:0] sign_t;

    localparam sign_t SIGN_ROCK     = 2'b00;
    localparam sign_t SIGN_SCISSORS = 2'b01;
    localparam sign_t SIGN_PAPER    = 2'b10;
    localparam sign_t SIGN_INVALID  = 2'b11;

    typedef enum logic [1:0] {
        ST_DECIDE = 2'd0,
        ST_ATK_A  = 2'd1,
        ST_ATK_B  = 2'd2,
        ST_OVER   = 2'd3
    } state_t;

    typedef logic [0:12] pat_t;

    localparam pat_t PAT_ROCK     = 13'b0011101000111;
    localparam pat_t PAT_SCISSORS = 13'b0011101101010;
    localparam pat_t PAT_PAPER    = 13'b0111111010000;
    localparam pat_t PAT_INVALID  = 13'b0000000101101;

    // Result screens shown once the game is over.
    localparam pat_t PAT_RES_DASH    = 13'b0000001000000;
    localparam pat_t PAT_RES_A_WIN_R = 13'b0000000100100;
    localparam pat_t PAT_RES_B_WIN_L = 13'b0000000001001;

    localparam pat_t PAT_DIG_0 = 13'b1111110000000;
    localparam pat_t PAT_DIG_1 = 13'b0110000000000;
    localparam pat_t PAT_DIG_2 = 13'b1101101000000;
    localparam pat_t PAT_DIG_3 = 13'b1111001000000;
    localparam pat_t PAT_DIG_4 = 13'b0110011000000;
    localparam pat_t PAT_DIG_5 = 13'b1011011000000;
    localparam pat_t PAT_DIG_6 = 13'b1011111000000;
    localparam pat_t PAT_DIG_7 = 13'b1110010000000;
    localparam pat_t PAT_DIG_8 = 13'b1111111000000;
    localparam pat_t PAT_DIG_9 = 13'b1111011000000;

    function automatic pat_t sign_pat(input sign_t s);
        case (s)
            SIGN_ROCK:     return PAT_ROCK;
            SIGN_SCISSORS: return PAT_SCISSORS;
            SIGN_PAPER:    return PAT_PAPER;
            default:       return PAT_INVALID;
        endcase
    endfunction

    // True when sign a beats sign b; both must be valid and different.
    function automatic logic beats(input sign_t a, input sign_t b);
        return ((a == SIGN_ROCK)     && (b == SIGN_SCISSORS)) ||
               ((a == SIGN_SCISSORS) && (b == SIGN_PAPER))    ||
               ((a == SIGN_PAPER)    && (b == SIGN_ROCK));
    endfunction

endpackage

// File: rtl/mjp_game_engine_digit_enc.sv
// mjp_digit_enc: combinational score digit to 13-bit segment pattern.
//   score : in  [3:0]  score value 0..9
//   pat   : out [0:12] segments a..g on bits 0..6, bits 7..12 zero
// Values above 9 cannot occur (scores saturate at WIN_SCORE <= 9) and blank.
module mjp_digit_enc
    import mjp_pkg::*;
(
    input  logic [3:0] score,
    output pat_t       pat
);

    always_comb begin
        case (score)
            4'd0:    pat = PAT_DIG_0;
            4'd1:    pat = PAT_DIG_1;
            4'd2:    pat = PAT_DIG_2;
            4'd3:    pat = PAT_DIG_3;
            4'd4:    pat = PAT_DIG_4;
            4'd5:    pat = PAT_DIG_5;
            4'd6:    pat = PAT_DIG_6;
            4'd7:    pat = PAT_DIG_7;
            4'd8:    pat = PAT_DIG_8;
            4'd9:    pat = PAT_DIG_9;
            default: pat = '0;
        endcase
    end

endmodule

// File: rtl/mjp_game_engine.sv
// mjp_game_engine: muk-jji-ppa game engine, one game per reset.
// Samples both throws on every CLK edge with PLAY=1, runs the RPS decide
// phase and the attack phase, keeps scores and round count, declares a winner.
//
// Optional feature macro: MJP_ROUND_LIMIT_EN
//   defined   -> game also ends after MAX_ROUNDS counted rounds (higher score
//                wins, equal scores draw)
//   undefined -> game ends only when a score reaches WIN_SCORE
//
// Ports:
//   CLK, RST   clock, synchronous active-high reset
//   PLAY       round strobe (level, one round per cycle while high)
//   A_IN, B_IN player signs: ROCK=00 SCISSORS=01 PAPER=10 INVALID=11
//   LDISP      A hand / result pattern       (registered)
//   RDISP      B hand / result pattern       (registered)
//   SC_LDISP   A score digit pattern         (registered)
//   SC_RDISP   B score digit pattern         (registered)
//   ATTACKER   00 none, 01 A, 10 B           (registered)
//   DONE       game over                     (registered)
//
// state     | meaning
// ----------+-------------------------------------------
// ST_DECIDE | rock-paper-scissors picks the attacker
// ST_ATK_A  | A attacks; a matching throw scores for A
// ST_ATK_B  | B attacks; a matching throw scores for B
// ST_OVER   | game finished, outputs frozen until RST
module mjp_game_engine
    import mjp_pkg::*;
#(
    parameter int WIN_SCORE  = 3,
    parameter int MAX_ROUNDS = 20
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        PLAY,
    input  logic [0:1]  A_IN,
    input  logic [0:1]  B_IN,
    output logic [0:12] LDISP,
    output logic [0:12] RDISP,
    output logic [0:12] SC_LDISP,
    output logic [0:12] SC_RDISP,
    output logic [0:1]  ATTACKER,
    output logic        DONE
);

`ifdef MJP_ROUND_LIMIT_EN
    localparam bit LIM_EN = 1'b1;
`else
    localparam bit LIM_EN = 1'b0;
`endif

    localparam logic [3:0] WIN_LIM = 4'(WIN_SCORE);
    localparam logic [7:0] RND_LIM = 8'(MAX_ROUNDS);

    state_t     state, nxt_state;
    logic [3:0] score_a, score_b, nxt_score_a, nxt_score_b;
    logic [7:0] rnd_cnt, nxt_rnd;
    pat_t       nxt_ldisp, nxt_rdisp, sc_a_pat, sc_b_pat;
    logic       a_won, b_won, draw;
    sign_t      a_sign, b_sign;

    assign a_sign = A_IN;
    assign b_sign = B_IN;

    always_comb begin
        nxt_state   = state;
        nxt_score_a = score_a;
        nxt_score_b = score_b;
        nxt_rnd     = rnd_cnt;
        nxt_ldisp   = LDISP;
        nxt_rdisp   = RDISP;
        a_won       = 1'b0;
        b_won       = 1'b0;
        draw        = 1'b0;
        if (PLAY && (state != ST_OVER)) begin
            nxt_ldisp = sign_pat(a_sign);
            nxt_rdisp = sign_pat(b_sign);
            if ((a_sign != SIGN_INVALID) && (b_sign != SIGN_INVALID)) begin
                nxt_rnd = rnd_cnt + 8'd1;
                if (a_sign == b_sign) begin
                    case (state)
                        ST_ATK_A: begin
                            nxt_score_a = (score_a < WIN_LIM) ? score_a + 4'd1 : score_a;
                            a_won       = (nxt_score_a == WIN_LIM);
                            nxt_state   = ST_DECIDE;
                        end
                        ST_ATK_B: begin
                            nxt_score_b = (score_b < WIN_LIM) ? score_b + 4'd1 : score_b;
                            b_won       = (nxt_score_b == WIN_LIM);
                            nxt_state   = ST_DECIDE;
                        end
                        default: ;
                    endcase
                end else begin
                    nxt_state = beats(a_sign, b_sign) ? ST_ATK_A : ST_ATK_B;
                end
                // A score win on the limit round takes precedence over the limit.
                if (LIM_EN && !a_won && !b_won && (nxt_rnd == RND_LIM)) begin
                    a_won = (nxt_score_a > nxt_score_b);
                    b_won = (nxt_score_b > nxt_score_a);
                    draw  = (nxt_score_a == nxt_score_b);
                end
                if (a_won) begin
                    nxt_state = ST_OVER;
                    nxt_ldisp = PAT_RES_DASH;
                    nxt_rdisp = PAT_RES_A_WIN_R;
                end else if (b_won) begin
                    nxt_state = ST_OVER;
                    nxt_ldisp = PAT_RES_B_WIN_L;
                    nxt_rdisp = PAT_RES_DASH;
                end else if (draw) begin
                    nxt_state = ST_OVER;
                    nxt_ldisp = PAT_RES_DASH;
                    nxt_rdisp = PAT_RES_DASH;
                end
            end
        end
    end

    // Encoders look at next-state scores so the digit buses update on the
    // same edge as the score registers.
    mjp_digit_enc u_enc_a (
        .score (nxt_score_a),
        .pat   (sc_a_pat)
    );

    mjp_digit_enc u_enc_b (
        .score (nxt_score_b),
        .pat   (sc_b_pat)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_DECIDE;
            score_a  <= '0;
            score_b  <= '0;
            rnd_cnt  <= '0;
            LDISP    <= PAT_INVALID;
            RDISP    <= PAT_INVALID;
            SC_LDISP <= PAT_DIG_0;
            SC_RDISP <= PAT_DIG_0;
            ATTACKER <= 2'b00;
            DONE     <= 1'b0;
        end else begin
            state    <= nxt_state;
            score_a  <= nxt_score_a;
            score_b  <= nxt_score_b;
            rnd_cnt  <= nxt_rnd;
            LDISP    <= nxt_ldisp;
            RDISP    <= nxt_rdisp;
            SC_LDISP <= sc_a_pat;
            SC_RDISP <= sc_b_pat;
            ATTACKER <= (nxt_state == ST_ATK_A) ? 2'b01 :
                        (nxt_state == ST_ATK_B) ? 2'b10 : 2'b00;
            DONE     <= (nxt_state == ST_OVER);
        end
    end

endmodule

// File: tb/tb_mjp_game_engine.sv
module tb_mjp_game_engine;

    localparam int WIN  = 3;
    localparam int MAXR = 20;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        PLAY = 1'b0;
    logic [0:1]  A_IN = 2'b00;
    logic [0:1]  B_IN = 2'b00;
    logic [0:12] LDISP, RDISP, SC_LDISP, SC_RDISP;
    logic [0:1]  ATTACKER;
    logic        DONE;

    always #5 CLK = ~CLK;

    mjp_game_engine #(.WIN_SCORE(WIN), .MAX_ROUNDS(MAXR)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .PLAY     (PLAY),
        .A_IN     (A_IN),
        .B_IN     (B_IN),
        .LDISP    (LDISP),
        .RDISP    (RDISP),
        .SC_LDISP (SC_LDISP),
        .SC_RDISP (SC_RDISP),
        .ATTACKER (ATTACKER),
        .DONE     (DONE)
    );

    typedef struct {
        logic [0:12] l;
        logic [0:12] r;
        logic [0:12] sl;
        logic [0:12] sr;
        logic [0:1]  att;
        logic        done;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: mode 0 decide, 1 A attacks, 2 B attacks, 3 over.
    int          m_mode, m_sa, m_sb, m_rnd;
    logic [0:12] m_l, m_r;

    function automatic logic [0:12] sign_p(input int s);
        case (s)
            0:       return 13'b0011101000111;
            1:       return 13'b0011101101010;
            2:       return 13'b0111111010000;
            default: return 13'b0000000101101;
        endcase
    endfunction

    function automatic logic [0:12] digit_p(input int d);
        case (d)
            0: return 13'b1111110000000;
            1: return 13'b0110000000000;
            2: return 13'b1101101000000;
            3: return 13'b1111001000000;
            4: return 13'b0110011000000;
            5: return 13'b1011011000000;
            6: return 13'b1011111000000;
            7: return 13'b1110010000000;
            8: return 13'b1111111000000;
            default: return 13'b1111011000000;
        endcase
    endfunction

    // ROCK=0, SCISSORS=1, PAPER=2: each sign beats the next one modulo 3.
    function automatic bit m_beats(input int a, input int b);
        return ((b - a + 3) % 3) == 1;
    endfunction

    task automatic model_step(input bit rst, input bit play, input int a, input int b);
        int winner;
        exp_t e;
        winner = 0;
        if (rst) begin
            m_mode = 0; m_sa = 0; m_sb = 0; m_rnd = 0;
            m_l = sign_p(3); m_r = sign_p(3);
        end else if (play && m_mode != 3) begin
            m_l = sign_p(a);
            m_r = sign_p(b);
            if (a != 3 && b != 3) begin
                m_rnd = (m_rnd + 1) % 256;
                if (a == b) begin
                    if (m_mode == 1) begin
                        m_sa++;
                        if (m_sa == WIN) winner = 1;
                        m_mode = 0;
                    end else if (m_mode == 2) begin
                        m_sb++;
                        if (m_sb == WIN) winner = 2;
                        m_mode = 0;
                    end
                end else begin
                    m_mode = m_beats(a, b) ? 1 : 2;
                end
`ifdef MJP_ROUND_LIMIT_EN
                if (winner == 0 && m_rnd == MAXR)
                    winner = (m_sa > m_sb) ? 1 : (m_sb > m_sa) ? 2 : 3;
`endif
                if (winner != 0) begin
                    m_mode = 3;
                    m_l = (winner == 2) ? 13'b0000000001001 : 13'b0000001000000;
                    m_r = (winner == 1) ? 13'b0000000100100 : 13'b0000001000000;
                end
            end
        end
        e.l    = m_l;
        e.r    = m_r;
        e.sl   = digit_p(m_sa);
        e.sr   = digit_p(m_sb);
        e.att  = (m_mode == 1) ? 2'b01 : (m_mode == 2) ? 2'b10 : 2'b00;
        e.done = (m_mode == 3);
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit rst, input bit play, input int a, input int b);
        RST  = rst;
        PLAY = play;
        A_IN = a[1:0];
        B_IN = b[1:0];
        model_step(rst, play, a, b);
        @(negedge CLK);
    endtask

    task automatic chk(input string name, input logic [0:12] act, input logic [0:12] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %b want %b at %0t", name, act, want, $time);
        end
    endtask

    // Monitor: the DUT presents a result one cycle after each driven edge.
    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ldisp",    LDISP,    e.l);
            chk("rdisp",    RDISP,    e.r);
            chk("sc_ldisp", SC_LDISP, e.sl);
            chk("sc_rdisp", SC_RDISP, e.sr);
            chk("attacker", {11'b0, ATTACKER}, {11'b0, e.att});
            chk("done",     {12'b0, DONE},     {12'b0, e.done});
        end
    end

    initial begin
        int a, b;
        // Directed: reset, decide, attack hit, switch, invalid, idle.
        drive(1, 0, 0, 0);
        drive(0, 1, 0, 1);
        drive(0, 1, 2, 2);
        drive(0, 1, 0, 1);
        drive(0, 1, 0, 2);
        drive(0, 1, 3, 0);
        drive(0, 0, 1, 1);
        drive(0, 1, 1, 3);
        // Reset wins over PLAY on the same edge.
        drive(1, 1, 0, 1);
        // A wins by three attack hits, then PLAY must change nothing.
        for (int i = 0; i < WIN; i++) begin
            drive(0, 1, 0, 1);
            drive(0, 1, 2, 2);
        end
        drive(0, 1, 0, 1);
        drive(0, 1, 1, 1);
        drive(0, 1, 2, 0);
        // B wins path.
        drive(1, 0, 0, 0);
        for (int i = 0; i < WIN; i++) begin
            drive(0, 1, 1, 0);
            drive(0, 1, 1, 1);
        end
        drive(0, 1, 0, 1);
        // Long run of decide ties: only ends if a round limit is built in.
        drive(1, 0, 0, 0);
        for (int i = 0; i < MAXR + 3; i++) drive(0, 1, 0, 0);
        // Randomized games.
        drive(1, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0 || (m_mode == 3 && $urandom_range(0, 7) == 0)) begin
                drive(1, $urandom_range(0, 1), 0, 1);
            end else begin
                a = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
                b = ($urandom_range(0, 2) == 0) ? a : $urandom_range(0, 3);
                drive(0, $urandom_range(0, 3) != 0, a, b);
            end
        end
        PLAY = 1'b0;
        RST  = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
